// File: rtl/proc_hier_top.sv
// Single-cycle 16-bit WISC-subset core with unified memory, 8x16 register file and trace ports.
// Optional PERF_CNT_EN macro adds the inst_count retired-instruction counter output.
module proc_hier_top #(
    parameter int    MEM_WORDS = 32768,
    parameter string MEM_FILE  = "loadfile_all.img"
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc,
    output logic [15:0] inst,
    output logic        reg_write,
    output logic [2:0]  write_reg,
    output logic [15:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        halt,
    output logic [31:0] cycle_count,
    output logic        icache_req,
    output logic        icache_hit,
    output logic        dcache_req,
    output logic        dcache_hit
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] inst_count
`endif
);

    localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_RTYPE = 5'b11011;

    // The memory image named by MEM_FILE is preloaded into mem by the simulation environment.
    logic [15:0] mem [MEM_WORDS];
    logic [15:0] regs [8];

    logic [15:0] pcReg;
    logic        halted;
    logic [31:0] cycleCnt;

    logic [4:0]  opcode;
    logic [2:0]  rsIdx;
    logic [2:0]  rtIdx;
    logic [2:0]  rdIdx;
    logic [1:0]  func;
    logic [15:0] rsVal;
    logic [15:0] rtVal;
    logic signed [15:0] imm5s;
    logic signed [15:0] imm8s;
    logic signed [15:0] imm11s;
    logic [15:0] imm5z;
    logic [15:0] pcPlus2;
    logic [15:0] dataAddr;
    logic [15:0] loadData;

    logic [15:0] nextPc;
    logic        wrEn;
    logic [2:0]  wrReg;
    logic [15:0] wrData;
    logic        ldEn;
    logic        stEn;
    logic        haltExec;
    logic        active;

    // Byte address to word index; bit 0 is dropped and the index wraps at MEM_WORDS.
    function automatic logic [AW-1:0] wordIdx(input logic [14:0] w);
        return AW'({17'd0, w} % MEM_WORDS_U);
    endfunction

    assign inst     = mem[wordIdx(pcReg[15:1])];
    assign opcode   = inst[15:11];
    assign rsIdx    = inst[10:8];
    assign rtIdx    = inst[7:5];
    assign rdIdx    = inst[4:2];
    assign func     = inst[1:0];
    assign rsVal    = regs[rsIdx];
    assign rtVal    = regs[rtIdx];
    assign imm5s    = {{11{inst[4]}}, inst[4:0]};
    assign imm8s    = {{8{inst[7]}}, inst[7:0]};
    assign imm11s   = {{5{inst[10]}}, inst[10:0]};
    assign imm5z    = {11'd0, inst[4:0]};
    assign pcPlus2  = pcReg + 16'd2;
    assign dataAddr = rsVal + imm5s;
    assign loadData = mem[wordIdx(dataAddr[15:1])];

    always_comb begin
        nextPc   = pcPlus2;
        wrEn     = 1'b0;
        wrReg    = rtIdx;
        wrData   = 16'd0;
        ldEn     = 1'b0;
        stEn     = 1'b0;
        haltExec = 1'b0;
        case (opcode)
            OP_HALT:  haltExec = 1'b1;
            OP_NOP:   ;
            OP_ADDI:  begin wrEn = 1'b1; wrData = rsVal + imm5s; end
            OP_SUBI:  begin wrEn = 1'b1; wrData = imm5s - rsVal; end
            OP_XORI:  begin wrEn = 1'b1; wrData = rsVal ^ imm5z; end
            OP_ANDNI: begin wrEn = 1'b1; wrData = rsVal & ~imm5z; end
            OP_ST:    stEn = 1'b1;
            OP_LD:    begin wrEn = 1'b1; ldEn = 1'b1; wrData = loadData; end
            OP_LBI:   begin wrEn = 1'b1; wrReg = rsIdx; wrData = imm8s; end
            OP_RTYPE: begin
                wrEn  = 1'b1;
                wrReg = rdIdx;
                case (func)
                    2'b00:   wrData = rsVal + rtVal;
                    2'b01:   wrData = rtVal - rsVal;
                    2'b10:   wrData = rsVal ^ rtVal;
                    default: wrData = rsVal & ~rtVal;
                endcase
            end
            OP_BEQZ:  if (rsVal == 16'd0) nextPc = pcPlus2 + imm8s;
            OP_BNEZ:  if (rsVal != 16'd0) nextPc = pcPlus2 + imm8s;
            OP_J:     nextPc = pcPlus2 + imm11s;
            default:  ;
        endcase
    end

    // Strobes are masked while in reset and once halted, so neither state can commit anything.
    assign active       = !rst && !halted;
    assign reg_write    = wrEn && active;
    assign mem_read     = ldEn && active;
    assign mem_write    = stEn && active;
    assign halt         = !rst && (halted || haltExec);
    assign write_reg    = wrReg;
    assign write_data   = wrData;
    assign mem_addr     = dataAddr;
    assign mem_data_in  = rtVal;
    assign mem_data_out = loadData;
    assign pc           = pcReg;
    assign cycle_count  = cycleCnt;
    assign icache_req   = !halt;
    assign icache_hit   = !halt;
    assign dcache_req   = mem_read || mem_write;
    assign dcache_hit   = mem_read || mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcReg    <= 16'd0;
            halted   <= 1'b0;
            cycleCnt <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'd0;
            end
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (!halted) begin
                if (haltExec) begin
                    halted <= 1'b1;
                end else begin
                    pcReg <= nextPc;
                end
            end
            if (reg_write) begin
                regs[wrReg] <= wrData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wordIdx(dataAddr[15:1])] <= rtVal;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] instCnt;

    // The HALT instruction itself counts once; later halted cycles do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instCnt <= 32'd0;
        end else if (reg_write || mem_write || (haltExec && !halted)) begin
            instCnt <= instCnt + 32'd1;
        end
    end

    assign inst_count = instCnt;
`endif

endmodule

// File: tb/tb_proc_hier_top.sv
// Scoreboard bench for proc_hier_top: programs are poked into memory, expected trace records queued.
module tb_proc_hier_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        halt;
    logic [31:0] cycle_count;
    logic        icache_req;
    logic        icache_hit;
    logic        dcache_req;
    logic        dcache_hit;
`ifdef PERF_CNT_EN
    logic [31:0] inst_count;
`endif

    proc_hier_top dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .inst        (inst),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out),
        .halt        (halt),
        .cycle_count (cycle_count),
        .icache_req  (icache_req),
        .icache_hit  (icache_hit),
        .dcache_req  (dcache_req),
        .dcache_hit  (dcache_hit)
`ifdef PERF_CNT_EN
        ,
        .inst_count  (inst_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic        mr;
        logic        mw;
        logic [15:0] ma;
        logic [15:0] md;
        logic        hlt;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] ccExp = 32'd0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] encR(input logic [2:0] rs, input logic [2:0] rt,
                                         input logic [2:0] rd, input logic [1:0] fn);
        return {5'b11011, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] encI(input logic [4:0] op, input logic [2:0] rs,
                                         input logic [2:0] rd, input logic [4:0] imm);
        return {op, rs, rd, imm};
    endfunction

    function automatic logic [15:0] encB(input logic [4:0] op, input logic [2:0] rs,
                                         input logic [7:0] imm);
        return {op, rs, imm};
    endfunction

    task automatic loadWord(input logic [15:0] byteAddr, input logic [15:0] w);
        dut.mem[byteAddr[15:1]] = w;
    endtask

    task automatic pushRec(input logic [15:0] p, input logic rw, input logic [2:0] wr,
                           input logic [15:0] wd, input logic mr, input logic mw,
                           input logic [15:0] ma, input logic [15:0] md, input logic hlt);
        exp_t e;
        e.pc = p; e.rw = rw; e.wr = wr; e.wd = wd; e.mr = mr; e.mw = mw;
        e.ma = ma; e.md = md; e.hlt = hlt;
        sb.push_back(e);
    endtask

    task automatic pw(input logic [15:0] p, input logic [2:0] wr, input logic [15:0] wd);
        pushRec(p, 1'b1, wr, wd, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic pn(input logic [15:0] p);
        pushRec(p, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic ph(input logic [15:0] p);
        pushRec(p, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    endtask

    task automatic checkOne();
        exp_t e;
        if (sb.size() == 0) begin
            checkVal("scoreboard_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        checkVal("pc", 32'(pc), 32'(e.pc));
        checkVal("reg_write", 32'(reg_write), 32'(e.rw));
        if (e.rw) begin
            checkVal("write_reg", 32'(write_reg), 32'(e.wr));
            checkVal("write_data", 32'(write_data), 32'(e.wd));
        end
        checkVal("mem_read", 32'(mem_read), 32'(e.mr));
        checkVal("mem_write", 32'(mem_write), 32'(e.mw));
        if (e.mr || e.mw) checkVal("mem_addr", 32'(mem_addr), 32'(e.ma));
        if (e.mr) checkVal("mem_data_out", 32'(mem_data_out), 32'(e.md));
        if (e.mw) checkVal("mem_data_in", 32'(mem_data_in), 32'(e.md));
        checkVal("halt", 32'(halt), 32'(e.hlt));
        checkVal("icache_req", 32'(icache_req & icache_hit), 32'(!e.hlt));
        checkVal("dcache_req", 32'(dcache_req & dcache_hit), 32'(e.mr | e.mw));
        checkVal("cycle_count", cycle_count, ccExp);
        ccExp = ccExp + 32'd1;
    endtask

    task automatic runChecks(input int n);
        #1 checkOne();
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            #1 checkOne();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_pc"}, 32'(pc), 32'd0);
        checkVal({tag, "_cycle"}, cycle_count, 32'd0);
        checkVal({tag, "_regw"}, 32'(reg_write), 32'd0);
        checkVal({tag, "_memr"}, 32'(mem_read), 32'd0);
        checkVal({tag, "_memw"}, 32'(mem_write), 32'd0);
        checkVal({tag, "_halt"}, 32'(halt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 checkResetOutputs("reset");

        // Program 1: LBI sign extension, then HALT at 0x0008 followed by halted cycles.
        loadWord(16'h0000, encB(5'b11000, 3'd1, 8'h7F));
        loadWord(16'h0002, encB(5'b11000, 3'd2, 8'h80));
        loadWord(16'h0004, encR(3'd1, 3'd2, 3'd3, 2'd0));
        loadWord(16'h0006, 16'h0800);
        loadWord(16'h0008, 16'h0000);
        pw(16'h0000, 3'd1, 16'h007F);
        pw(16'h0002, 3'd2, 16'hFF80);
        pw(16'h0004, 3'd3, 16'hFFFF);
        pn(16'h0006);
        for (int i = 0; i < 4; i++) ph(16'h0008);
        ccExp = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        runChecks(8);
`ifdef PERF_CNT_EN
        checkVal("inst_count", inst_count, 32'd4);
`endif

        // Program 2: ALU, memory, branches and jumps.
        @(negedge clk);
        rst = 1'b1;
        #1 checkResetOutputs("reset2");
        loadWord(16'h0000, encB(5'b11000, 3'd1, 8'd5));
        loadWord(16'h0002, encB(5'b11000, 3'd2, 8'd3));
        loadWord(16'h0004, encR(3'd1, 3'd2, 3'd3, 2'd0));
        loadWord(16'h0006, encR(3'd1, 3'd2, 3'd3, 2'd1));
        loadWord(16'h0008, encR(3'd1, 3'd2, 3'd3, 2'd3));
        loadWord(16'h000A, encB(5'b11000, 3'd1, 8'h40));
        loadWord(16'h000C, encR(3'd1, 3'd1, 3'd1, 2'd0));
        loadWord(16'h000E, encR(3'd1, 3'd1, 3'd1, 2'd0));
        loadWord(16'h0010, encB(5'b01100, 3'd0, 8'd4));
        loadWord(16'h0012, encB(5'b11000, 3'd7, 8'h55));
        loadWord(16'h0014, encB(5'b11000, 3'd7, 8'h55));
        loadWord(16'h0016, encB(5'b01101, 3'd0, 8'd4));
        loadWord(16'h0018, encI(5'b10001, 3'd1, 3'd2, 5'd4));
        loadWord(16'h001A, encI(5'b10000, 3'd1, 3'd2, 5'd2));
        loadWord(16'h001C, encI(5'b10001, 3'd1, 3'd4, 5'd2));
        loadWord(16'h001E, encI(5'b01000, 3'd4, 3'd5, 5'h1F));
        loadWord(16'h0020, encI(5'b01001, 3'd1, 3'd6, 5'd1));
        loadWord(16'h0022, encI(5'b01010, 3'd2, 3'd6, 5'h1F));
        loadWord(16'h0024, encI(5'b01011, 3'd2, 3'd7, 5'h1F));
        loadWord(16'h0026, {5'b00100, 11'd2});
        loadWord(16'h0028, encB(5'b11000, 3'd7, 8'h55));
        loadWord(16'h002A, encB(5'b01101, 3'd1, 8'd2));
        loadWord(16'h002C, encB(5'b11000, 3'd7, 8'h55));
        loadWord(16'h002E, 16'h0800);
        loadWord(16'h0030, encB(5'b11000, 3'd3, 8'h12));
        loadWord(16'h0102, 16'h0000);
        loadWord(16'h0104, 16'hBEEF);

        pw(16'h0000, 3'd1, 16'h0005);
        pw(16'h0002, 3'd2, 16'h0003);
        pw(16'h0004, 3'd3, 16'h0008);
        pw(16'h0006, 3'd3, 16'hFFFE);
        pw(16'h0008, 3'd3, 16'h0004);
        pw(16'h000A, 3'd1, 16'h0040);
        pw(16'h000C, 3'd1, 16'h0080);
        pw(16'h000E, 3'd1, 16'h0100);
        pn(16'h0010);
        pn(16'h0016);
        pushRec(16'h0018, 1'b1, 3'd2, 16'hBEEF, 1'b1, 1'b0, 16'h0104, 16'hBEEF, 1'b0);
        pushRec(16'h001A, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0102, 16'hBEEF, 1'b0);
        pushRec(16'h001C, 1'b1, 3'd4, 16'hBEEF, 1'b1, 1'b0, 16'h0102, 16'hBEEF, 1'b0);
        pw(16'h001E, 3'd5, 16'hBEEE);
        pw(16'h0020, 3'd6, 16'hFF01);
        pw(16'h0022, 3'd6, 16'hBEF0);
        pw(16'h0024, 3'd7, 16'hBEE0);
        pn(16'h0026);
        pn(16'h002A);
        pn(16'h002E);
        pw(16'h0030, 3'd3, 16'h0012);
        ccExp = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        runChecks(21);

        // Reset in the middle of LBI r3: outputs drop at once and the write is lost.
        rst = 1'b1;
        #1 checkResetOutputs("midreset");
        checkVal("midreset_pending", 32'(sb.size()), 32'd0);
        @(negedge clk);
        loadWord(16'h0000, encR(3'd3, 3'd0, 3'd4, 2'd0));
        pw(16'h0000, 3'd4, 16'h0000);
        pw(16'h0002, 3'd2, 16'h0003);
        ccExp = 32'd0;
        rst = 1'b0;
        runChecks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_hier_top.md
Name: proc_hier_top

Overview:
- Self-contained 16-bit processor hierarchy for simulation: single-cycle WISC-subset core, unified program/data memory, 8x16 register file, free-running cycle counter.
- Exposes per-cycle architectural trace signals (PC, instruction, register write, memory access, halt) as ports.
- The system bench uses these ports to produce the SIMLOG/ptrace files and to end simulation on halt.

Parameters:
- MEM_WORDS, 32768, number of 16-bit memory words; byte address bits [15:1] index it, modulo MEM_WORDS.
- MEM_FILE, "loadfile_all.img", hex image loaded into memory at time 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- pc  output  16  byte address of the current instruction.
- inst  output  16  current instruction word, mem[pc>>1].
- reg_write  output  1  register file written at the next edge.
- write_reg  output  3  destination register.
- write_data  output  16  data written to the register.
- mem_read  output  1  load in progress.
- mem_write  output  1  store in progress.
- mem_addr  output  16  data byte address (Rs + sext(imm5)).
- mem_data_in  output  16  store data.
- mem_data_out  output  16  load data, mem[mem_addr>>1].
- halt  output  1  HALT is executing, or the core has already halted.
- cycle_count  output  32  cycles elapsed since reset.
- icache_req, icache_hit  output  1 each  both high each non-halted cycle; memory is ideal.
- dcache_req, dcache_hit  output  1 each  both equal mem_read|mem_write.

Behaviour:
- Reset, asynchronous:
  - pc=0, all registers=0, halted=0, cycle_count=0.
  - While rst is high, reg_write, mem_read, mem_write and halt are 0.
  - Memory contents are not reset.
- Timing:
  - Single-cycle datapath; all outputs are combinational from pc and state.
  - On each posedge with rst low: commit the register write, commit the store, update pc, and increment cycle_count (wraps at 2^32).
- Instruction formats:
  - opcode = inst[15:11]; Rs = inst[10:8]; Rt/Rd = inst[7:5]; R-type Rd = inst[4:2]; func = inst[1:0].
- Instruction set:
  - 00000 HALT: set sticky halted; pc frozen; no writes. Further cycles hold halt=1 with no writes or memory strobes until reset.
  - 00001 NOP.
  - 01000 ADDI: Rd = Rs + sext(imm5).
  - 01001 SUBI: Rd = sext(imm5) - Rs.
  - 01010 XORI: Rd = Rs ^ zext(imm5).
  - 01011 ANDNI: Rd = Rs & ~zext(imm5).
  - 10000 ST: mem[Rs+sext(imm5)] = Rd.
  - 10001 LD: Rd = mem[Rs+sext(imm5)].
  - 11000 LBI: Rs = sext(inst[7:0]); write_reg = Rs.
  - 11011 R-type, by func:
    - 00 ADD: Rs+Rt.
    - 01 SUB: Rt-Rs.
    - 10 XOR.
    - 11 ANDN: Rs & ~Rt.
  - 01100 BEQZ / 01101 BNEZ: if Rs==0 (resp. !=0), pc = pc+2+sext(imm8); otherwise pc = pc+2.
  - 00100 J: pc = pc+2+sext(inst[10:0]).
  - Any other opcode behaves as NOP.
- Arithmetic: 16-bit, modulo 2^16, no flags.
- PC: pc+2 normally, wraps 0xFFFE -> 0x0000.
- Memory:
  - Byte address bit 0 is ignored (word-aligned).
  - Load data is combinational.
  - A store is visible from the next cycle.
  - A store to the address of the currently executing instruction takes effect next cycle.
- Register file: combinational read, write at posedge; reading the destination in the same cycle returns the old value.
- Reset asserted mid-program aborts the pending writes of that cycle.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - Adds output inst_count [31:0], cleared by reset.
  - Increments on each posedge where reg_write|mem_write, and once on the HALT cycle. It does not increment on subsequent halted cycles.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset then LBI r1,0x7F; LBI r2,0x80 -> reg_write=1 with write_reg=1 data 0x007F, then write_reg=2 data 0xFF80; pc 0x0000 -> 0x0002 -> 0x0004.
- r1=0x0005, r2=0x0003: ADD r3 / SUB r3 / ANDN r3 -> write_data 0x0008, 0xFFFE, 0x0004.
- r1=0x0100, r2=0xBEEF: ST r2,[r1+2] then LD r4,[r1+2]:
  - ST: mem_write=1, mem_addr=0x0102, mem_data_in=0xBEEF.
  - LD: mem_read=1, mem_data_out=0xBEEF, r4=0xBEEF.
- BEQZ r0,+4 at pc 0x0010 -> next pc 0x0016; BNEZ r0 at 0x0016 -> pc 0x0018.
- HALT at pc 0x0008 -> halt=1 that cycle; pc stays 0x0008; no writes for 3 further cycles; cycle_count keeps counting.
- Assert rst mid-program -> outputs immediately 0, pc=0, cycle_count=0; after release, execution restarts from 0x0000.
